shift_register_8bit: RTL and testbench
======================================

// Module: shift_register_8bit
// PURPOSE
//  - Loadable parallel-in/serial-out shift register used as a one-time-pad key-stream source.
//  - Parallel load of an N-bit pad; each shift presents the next pad bit, LSB first, on serial_out.
//  - Downstream logic XORs serial_out with message bits to encrypt.
//  - A second instance loaded with the same pad decrypts.
//  - With ROTATE=1 the pad recirculates, so it repeats every WIDTH shifts for messages longer than WIDTH.
// PARAMETERS
//  - WIDTH   8  register width in bits (>=2)
//  - ROTATE  1  1: circular rotate-right (bit0 re-enters at MSB); 0: logical shift-right, MSB fills 0
// PORTS
//  - clk         in   1      single clock, rising-edge active
//  - rst_n       in   1      asynchronous, active-low reset
//  - data        in   WIDTH  parallel pad value, sampled when load=1
//  - load        in   1      parallel load strobe
//  - sh          in   1      shift enable
//  - serial_out  out  1      current key bit = reg[0]
//  - Interface constraint: one clock; reset is asynchronous and active-low.
//  - Ports under CIPHER_XOR_EN:
//    - msg_in      in   1    plaintext/ciphertext bit
//    - cipher_out  out  1    msg_in ^ serial_out
// BEHAVIOUR
//  - Single internal WIDTH-bit register `reg`; all state changes on posedge clk.
//    - rst_n=0 is the only exception: it clears reg immediately, regardless of clk.
//  - Reset values:
//    - reg = 0; serial_out = 0.
//    - cipher_out = msg_in (XOR with 0), combinational.
//  - Priority at each rising edge (reset not asserted):
//    1. load=1 -> reg <= data. sh is ignored, so load beats a simultaneous shift.
//    2. load=0, sh=1, ROTATE=1 -> reg <= {reg[0], reg[WIDTH-1:1]}
//    3. load=0, sh=1, ROTATE=0 -> reg <= {1'b0, reg[WIDTH-1:1]}
//    4. load=0, sh=0 -> hold.
//  - serial_out is combinational from reg[0]. No output register.
//    - After a load it shows data[0] in the same cycle the load completes.
//    - Each shift edge advances it by one bit: zero extra latency.
//  - Wrap-around:
//    - ROTATE=1: after exactly WIDTH shifts reg equals the loaded value again; the sequence is periodic.
//    - ROTATE=0: after WIDTH shifts reg=0 and serial_out stays 0 until the next load.
//  - Reset mid-shift aborts the stream.
//    - After rst_n rises, reg stays 0 until a load.
//    - No state other than reg is kept.
//  - load held high across several edges: reg reloads every edge; no shifting occurs.
//  - data changes while load=0 have no effect.
//  - No X-propagation tolerance is required beyond standard RTL; inputs are assumed synchronous to clk.
// CONFIGURATION
//  - Macro CIPHER_XOR_EN.
//  - Defined:
//    - msg_in and cipher_out ports exist.
//    - cipher_out = msg_in ^ reg[0], purely combinational, so the block emits cipher bits directly.
//  - Undefined:
//    - Neither port exists; the external user performs the XOR.
//    - serial_out and all register behaviour are identical in both builds.
// TESTING
//  - Reset: rst_n=0 asynchronously, mid-cycle -> serial_out=0 before the next clk edge; reg=0x00.
//  - Load/shift 0x2A (ROTATE=1):
//    - load 8'h2A -> serial_out=0.
//    - 8 shifts -> serial_out bits 1,0,1,0,1,0,0, then 0 (reg back to 0x2A).
//    - Sequence repeats identically for shifts 9..16.
//  - Priority:
//    - reg=0x2A, load=1 and sh=1 with data=0xFF -> reg=0xFF, serial_out=1.
//    - Then sh=0,load=0 for 5 edges -> reg stays 0xFF.
//  - Encrypt/decrypt round trip:
//    - Two instances, both loaded with 0x2A, shifted in lockstep over 288 bits.
//    - Message is the ASCII string "Universidade Federal de Minas Gerais".
//    - Decrypted result equals the original message; ciphertext differs from it.
//  - ROTATE=0: load 0x81, 8 shifts -> serial_out 1,0,0,0,0,0,0,1, then constant 0 afterwards.
//  - CIPHER_XOR_EN: load 0x01, msg_in=1 -> cipher_out=0; after one shift -> cipher_out=1.

Source files
------------

// File: rtl/shift_register_8bit.sv
// Loadable PISO shift register used as a one-time-pad key-stream source (LSB first).
// Optional macro CIPHER_XOR_EN adds msg_in/cipher_out for an on-block XOR of the key bit.
module shift_register_8bit #(
    parameter int WIDTH  = 8,
    parameter int ROTATE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data,
    input  logic             load,
    input  logic             sh,
    output logic             serial_out
`ifdef CIPHER_XOR_EN
    ,
    input  logic             msg_in,
    output logic             cipher_out
`endif
);

    if (WIDTH < 2) begin : g_width_check
        $error("shift_register_8bit: WIDTH must be at least 2");
    end

    logic [WIDTH-1:0] pad;
    logic             fill;

    // Rotation recirculates the departing LSB so the pad repeats every WIDTH shifts.
    assign fill = (ROTATE != 0) ? pad[0] : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad <= '0;
        end else if (load) begin
            pad <= data;
        end else if (sh) begin
            pad <= {fill, pad[WIDTH-1:1]};
        end
    end

    assign serial_out = pad[0];

`ifdef CIPHER_XOR_EN
    assign cipher_out = msg_in ^ pad[0];
`endif

endmodule

// File: tb/tb_shift_register_8bit.sv
// Scoreboard bench for shift_register_8bit: directed vectors push expected key/cipher bits,
// a monitor pops and compares them after each clock edge (or an asynchronous-reset probe).
module tb_shift_register_8bit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data = 8'h00;
    logic       load = 1'b0;
    logic       sh = 1'b0;
    logic [7:0] data_c = 8'h00;
    logic       load_c = 1'b0;
    logic       sh_c = 1'b0;
    logic       msg = 1'b0;
    logic       probe = 1'b0;
    logic       ser_a, ser_b, ser_c;
    logic       cipher_a, dec;

    always #5 clk = ~clk;

    shift_register_8bit #(.WIDTH(8), .ROTATE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .data(data), .load(load), .sh(sh), .serial_out(ser_a)
`ifdef CIPHER_XOR_EN
        , .msg_in(msg), .cipher_out(cipher_a)
`endif
    );

    shift_register_8bit #(.WIDTH(8), .ROTATE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .data(data), .load(load), .sh(sh), .serial_out(ser_b)
`ifdef CIPHER_XOR_EN
        , .msg_in(cipher_a), .cipher_out(dec)
`endif
    );

    logic unused_c;
    shift_register_8bit #(.WIDTH(8), .ROTATE(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .data(data_c), .load(load_c), .sh(sh_c), .serial_out(ser_c)
`ifdef CIPHER_XOR_EN
        , .msg_in(1'b0), .cipher_out(unused_c)
`endif
    );

`ifndef CIPHER_XOR_EN
    assign cipher_a = msg ^ ser_a;
    assign dec      = cipher_a ^ ser_b;
    assign unused_c = 1'b0;
`endif

    typedef struct {
        int    kind;
        logic  exp;
        int    idx;
        string tag;
    } ent_t;

    ent_t  q[$];
    int    checks = 0;
    int    failures = 0;
    logic  ct [288];
    string msg_s = "Universidade Federal de Minas Gerais";
    int    pat [8] = '{0, 1, 0, 1, 0, 1, 0, 0};
    int    r0_exp [13] = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};

    function automatic logic msg_bit(input int k);
        byte c;
        c = byte'(msg_s[k / 8]);
        return c[k % 8];
    endfunction

    // Monitor: outputs settle right after each edge, or after an async reset probe.
    initial begin
        forever begin
            @(posedge clk or posedge probe);
            #1;
            while (q.size() != 0) begin
                ent_t e;
                logic act;
                e = q.pop_front();
                case (e.kind)
                    0: act = ser_a;
                    1: act = ser_c;
                    2: begin
                        act = dec;
                        ct[e.idx] = cipher_a;
                    end
                    default: act = cipher_a;
                endcase
                checks++;
                if (act !== e.exp) begin
                    failures++;
                    $display("FAIL %s[%0d] got=%b want=%b", e.tag, e.idx, act, e.exp);
                end
            end
        end
    end

    task automatic step(input logic ld, input logic s, input logic [7:0] d,
                        input int kind, input logic exp, input string tag, input int idx);
        @(negedge clk);
        load = ld;
        sh   = s;
        data = d;
        q.push_back('{kind, exp, idx, tag});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset dominates a load request.
        @(negedge clk);
        load = 1'b1; data = 8'hFF; load_c = 1'b1; data_c = 8'hFF;
        q.push_back('{0, 1'b0, 0, "reset_a"});
        q.push_back('{1, 1'b0, 0, "reset_c"});
        @(negedge clk);
        rst_n = 1'b1; load = 1'b0; load_c = 1'b0;

        // 0x2A rotate: key bits follow pat, period 8; data changes while idle are ignored.
        step(1'b1, 1'b0, 8'h2A, 0, 1'b0, "load_2a", 0);
        for (int i = 1; i <= 16; i++)
            step(1'b0, 1'b1, 8'h55 + 8'(i), 0, 1'(pat[i % 8]), "rot_2a", i);

        // load beats shift, then hold, then confirm 0xFF by rotating it fully.
        step(1'b1, 1'b1, 8'hFF, 0, 1'b1, "prio_load", 0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 0, 1'b1, "hold_ff", i);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00, 0, 1'b1, "rot_ff", i);

        // load held high reloads every edge without shifting.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'h02, 0, 1'b0, "load_held", i);

        // Asynchronous reset mid-stream, checked before the next edge.
        step(1'b1, 1'b0, 8'hFF, 0, 1'b1, "pre_rst", 0);
        @(negedge clk);
        load = 1'b0; sh = 1'b1;
        #2;
        rst_n = 1'b0;
        q.push_back('{0, 1'b0, 0, "async_rst"});
        probe = 1'b1;
        #2;
        probe = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hFF, 0, 1'b0, "post_rst", i);

        // Logical shift on dut_c: 0x81 drains to zero and stays there.
        @(negedge clk);
        sh = 1'b0; load_c = 1'b1; sh_c = 1'b0; data_c = 8'h81;
        q.push_back('{1, 1'(r0_exp[0]), 0, "shr_81"});
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            load_c = 1'b0; sh_c = 1'b1; data_c = 8'hFF;
            q.push_back('{1, 1'(r0_exp[i]), i, "shr_81"});
        end

        // Cipher bit: key 1 cancels msg 1, after one shift key 0 passes it.
        @(negedge clk);
        sh_c = 1'b0; msg = 1'b1;
        load = 1'b1; sh = 1'b0; data = 8'h01;
        q.push_back('{3, 1'b0, 0, "cipher"});
        step(1'b0, 1'b1, 8'h00, 3, 1'b1, "cipher", 1);

        // Encrypt/decrypt round trip over 288 message bits.
        @(negedge clk);
        load = 1'b1; sh = 1'b0; data = 8'h2A;
        for (int k = 0; k < 288; k++) begin
            @(negedge clk);
            load = 1'b0;
            sh   = (k > 0);
            msg  = msg_bit(k);
            q.push_back('{2, msg_bit(k), k, "roundtrip"});
            q.push_back('{0, 1'(pat[k % 8]), k, "rt_key"});
        end
        @(negedge clk);
        sh = 1'b0;

        for (int t = 0; t < 100 && q.size() != 0; t++) @(negedge clk);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d want=0", q.size());
        end

        begin
            int diff;
            diff = 0;
            for (int k = 0; k < 288; k++) if (ct[k] !== msg_bit(k)) diff++;
            checks++;
            if (diff == 0) begin
                failures++;
                $display("FAIL cipher_differs got=%0d want=nonzero", diff);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
